// File: rtl/fft_gain_cal_if.sv
// Spectrum-bin stream into the gain calibrator and the calibration result back out.
interface fft_gain_cal_if #(
  parameter int DW   = 24,
  parameter int NFFT = 1024
);
  localparam int AW = $clog2(NFFT);

  logic signed [DW-1:0] x_re;
  logic signed [DW-1:0] x_im;
  logic signed [DW-1:0] y_re;
  logic signed [DW-1:0] y_im;
  logic                 fft_out_valid;
  logic                 sof;
  logic [DW-1:0]        gain;
  logic [AW-1:0]        peak_bin;
  logic                 calvalid;
  logic                 div_zero;

  modport master (
    output x_re, x_im, y_re, y_im, fft_out_valid, sof,
    input  gain, peak_bin, calvalid, div_zero
  );

  modport slave (
    input  x_re, x_im, y_re, y_im, fft_out_valid, sof,
    output gain, peak_bin, calvalid, div_zero
  );
endinterface

// File: rtl/fft_gain_cal.sv
// Per-frame gain calibration: finds the bin with the strongest reference power and
// reports the response/reference power ratio at that bin through a restoring divider.
module fft_gain_cal #(
  parameter int DW   = 24,
  parameter int NFFT = 1024,
  parameter int FRAC = 12
) (
  input logic          clk,
  input logic          rst_n,
  fft_gain_cal_if.slave bus
);

  localparam int AW = $clog2(NFFT);
  localparam int PW = 2 * DW;
  localparam int SH = DW - FRAC;
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} div_state_t;

  logic [AW-1:0]        bin_cnt;
  logic [AW-1:0]        bin_now;
  logic signed [PW-1:0] xr_m, xi_m, yr_m, yi_m;

  logic                 v1, first1, last1;
  logic [AW-1:0]        idx1;
  logic [PW-1:0]        xr_sq, xi_sq, yr_sq, yi_sq;

  logic                 v2, first2, last2;
  logic [AW-1:0]        idx2;
  logic [PW-1:0]        px2, py2;

  logic [PW-1:0]        max_px, max_py;
  logic [AW-1:0]        max_idx;
  logic                 done3;

  logic [PW-1:0]        op_px, op_py;
  logic [AW-1:0]        op_idx;
  logic                 op_zero, op_sat, start;
  logic [PW+SH-1:0]     py_wide, px_scaled;

  div_state_t           state;
  logic [PW-1:0]        rem, rem_next;
  logic [DW-1:0]        nlo, quot, q_next;
  logic [CW-1:0]        cnt;
  logic [PW:0]          trial;
  logic                 take;

  logic [DW-1:0]        gain_r;
  logic [AW-1:0]        peak_r;
  logic                 calvalid_r, dz_r;

  always_comb begin
    bin_now = bus.sof ? '0 : bin_cnt;
    xr_m    = PW'(bus.x_re) * PW'(bus.x_re);
    xi_m    = PW'(bus.x_im) * PW'(bus.x_im);
    yr_m    = PW'(bus.y_re) * PW'(bus.y_re);
    yi_m    = PW'(bus.y_im) * PW'(bus.y_im);
  end

  // Stage 1: bin numbering and the four squares.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_cnt <= '0;
      v1      <= 1'b0;
      first1  <= 1'b0;
      last1   <= 1'b0;
      idx1    <= '0;
      xr_sq   <= '0;
      xi_sq   <= '0;
      yr_sq   <= '0;
      yi_sq   <= '0;
    end else begin
      v1 <= bus.fft_out_valid;
      if (bus.fft_out_valid) begin
        bin_cnt <= bin_now + AW'(1);
        idx1    <= bin_now;
        first1  <= (bin_now == '0);
        last1   <= (&bin_now);
        xr_sq   <= $unsigned(xr_m);
        xi_sq   <= $unsigned(xi_m);
        yr_sq   <= $unsigned(yr_m);
        yi_sq   <= $unsigned(yi_m);
      end
    end
  end

  // Stage 2: bin powers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2     <= 1'b0;
      first2 <= 1'b0;
      last2  <= 1'b0;
      idx2   <= '0;
      px2    <= '0;
      py2    <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        first2 <= first1;
        last2  <= last1;
        idx2   <= idx1;
        px2    <= xr_sq + xi_sq;
        py2    <= yr_sq + yi_sq;
      end
    end
  end

  // Bin 0 reloads the tracker unconditionally, so a new frame never sees stale maxima.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_px  <= '0;
      max_py  <= '0;
      max_idx <= '0;
      done3   <= 1'b0;
    end else begin
      done3 <= v2 && last2;
      if (v2 && (first2 || (px2 > max_px))) begin
        max_px  <= px2;
        max_py  <= py2;
        max_idx <= idx2;
      end
    end
  end

  // Quotient overflows DW bits exactly when py >= px * 2^(DW-FRAC).
  always_comb begin
    py_wide   = (PW+SH)'(max_py);
    px_scaled = (PW+SH)'(max_px) << SH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_px   <= '0;
      op_py   <= '0;
      op_idx  <= '0;
      op_zero <= 1'b0;
      op_sat  <= 1'b0;
      start   <= 1'b0;
    end else begin
      start <= done3;
      if (done3) begin
        op_px   <= max_px;
        op_py   <= max_py;
        op_idx  <= max_idx;
        op_zero <= (max_px == '0);
        op_sat  <= (py_wide >= px_scaled);
      end
    end
  end

  always_comb begin
    trial    = {rem, nlo[DW-1]};
    take     = (trial >= {1'b0, op_px});
    rem_next = take ? PW'(trial - {1'b0, op_px}) : PW'(trial);
    q_next   = {quot[DW-2:0], take};
  end

  // Divider walks py*2^FRAC / px one quotient bit per cycle; the remainder starts
  // pre-loaded with the upper dividend bits, which is valid whenever no saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rem        <= '0;
      nlo        <= '0;
      quot       <= '0;
      cnt        <= '0;
      gain_r     <= '0;
      peak_r     <= '0;
      calvalid_r <= 1'b0;
      dz_r       <= 1'b0;
    end else begin
      calvalid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rem   <= op_py >> SH;
            nlo   <= op_py[DW-1:0] << FRAC;
            quot  <= '0;
            cnt   <= '0;
            state <= DIV;
          end
        end
        DIV: begin
          rem  <= rem_next;
          nlo  <= nlo << 1;
          quot <= q_next;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(DW - 1)) begin
            gain_r     <= (op_zero || op_sat) ? '1 : q_next;
            peak_r     <= op_idx;
            dz_r       <= op_zero;
            calvalid_r <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gain     = gain_r;
  assign bus.peak_bin = peak_r;
  assign bus.calvalid = calvalid_r;
  assign bus.div_zero = dz_r;

endmodule

// File: tb/tb_fft_gain_cal.sv
// Scoreboard bench for fft_gain_cal: a frame model queues the expected result when
// the last bin is driven, and a calvalid monitor pops and compares it.
module tb_fft_gain_cal;

  localparam int DW   = 24;
  localparam int NFFT = 1024;
  localparam int FRAC = 12;
  localparam int AW   = $clog2(NFFT);

  typedef struct {
    logic [DW-1:0] gain;
    logic [AW-1:0] bin;
    logic          dz;
    int            accCyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  int   tbBin;
  longint maxPx, maxPy;
  int   maxIdx;
  exp_t sbQ[$];
  int   cvTimes[$];

  fft_gain_cal_if #(.DW(DW), .NFFT(NFFT)) bus ();

  fft_gain_cal #(.DW(DW), .NFFT(NFFT), .FRAC(FRAC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic void getSample(input int pat, input int bin,
                                    output int xr, output int xi, output int yr, output int yi);
    xr = 0; xi = 0; yr = 0; yi = 0;
    case (pat)
      0: begin xr = 1000; yr = 2000; end
      1: begin
        if (bin == 300) begin xr = 3; xi = -4; yi = 10; end
        else begin xr = 1; yr = 5; yi = 5; end
      end
      2: begin yr = 7; yi = 7; end
      3: begin xr = 1; yr = 2000; end
      default: begin xr = 2000; yr = 1000; end
    endcase
  endfunction

  // One accepted sample; updates the frame model and queues a result on the last bin.
  task automatic applyStimulus(input int pat, input bit sofBit);
    int xr, xi, yr, yi;
    longint px, py, q;
    exp_t e;
    if (sofBit) tbBin = 0;
    getSample(pat, tbBin, xr, xi, yr, yi);
    @(negedge clk);
    bus.x_re          = DW'(xr);
    bus.x_im          = DW'(xi);
    bus.y_re          = DW'(yr);
    bus.y_im          = DW'(yi);
    bus.sof           = sofBit;
    bus.fft_out_valid = 1'b1;
    px = longint'(xr) * xr + longint'(xi) * xi;
    py = longint'(yr) * yr + longint'(yi) * yi;
    if (tbBin == 0 || px > maxPx) begin
      maxPx  = px;
      maxPy  = py;
      maxIdx = tbBin;
    end
    if (tbBin == NFFT - 1) begin
      e.bin    = AW'(maxIdx);
      e.accCyc = cyc + 1;
      if (maxPx == 0) begin
        e.gain = '1;
        e.dz   = 1'b1;
      end else begin
        q      = (maxPy <<< FRAC) / maxPx;
        e.gain = (q >= (64'sd1 <<< DW)) ? '1 : q[DW-1:0];
        e.dz   = 1'b0;
      end
      sbQ.push_back(e);
    end
    tbBin = (tbBin + 1) % NFFT;
  endtask

  // Idle cycles hold sof high to show it is ignored without fft_out_valid.
  task automatic applyIdle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.fft_out_valid = 1'b0;
      bus.sof           = 1'b1;
    end
  endtask

  task automatic sendFrame(input int pat, input bit useSof, input int gapAfter);
    for (int b = 0; b < NFFT; b++) begin
      applyStimulus(pat, useSof && (b == 0));
      if (b == gapAfter) applyIdle(30000);
    end
  endtask

  task automatic sendPartial(input int pat, input int n);
    for (int b = 0; b < n; b++) applyStimulus(pat, b == 0);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput("drain", sbQ.size(), 0);
  endtask

  task automatic checkZeroOutputs(input string pfx);
    checkOutput({pfx, "Gain"}, bus.gain, 0);
    checkOutput({pfx, "Peak"}, bus.peak_bin, 0);
    checkOutput({pfx, "Calvalid"}, bus.calvalid, 0);
    checkOutput({pfx, "DivZero"}, bus.div_zero, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.calvalid) begin
      cvTimes.push_back(cyc);
      if (sbQ.size() == 0) begin
        checkOutput("spuriousCalvalid", 1, 0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("gain", bus.gain, e.gain);
        checkOutput("peakBin", bus.peak_bin, e.bin);
        checkOutput("divZero", bus.div_zero, e.dz);
        checkOutput("latency", cyc - e.accCyc, DW + 4);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks = 0; failures = 0; tbBin = 0;
    maxPx = 0; maxPy = 0; maxIdx = 0;
    bus.x_re = '0; bus.x_im = '0; bus.y_re = '0; bus.y_im = '0;
    bus.fft_out_valid = 1'b0; bus.sof = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkZeroOutputs("rst");
    rst_n = 1'b1;
    applyIdle(2);

    sendFrame(0, 1'b0, -1); applyIdle(1); waitDrain();
    sendFrame(1, 1'b1, -1); applyIdle(1); waitDrain();
    sendFrame(2, 1'b1, -1); applyIdle(1); waitDrain();
    sendFrame(3, 1'b0, -1); applyIdle(1); waitDrain();

    cvTimes.delete();
    sendFrame(0, 1'b1, 511);
    sendFrame(0, 1'b0, -1);
    applyIdle(1); waitDrain();
    checkOutput("b2bCount", cvTimes.size(), 2);
    if (cvTimes.size() == 2) checkOutput("b2bSpacing", cvTimes[1] - cvTimes[0], NFFT);

    sendPartial(0, 500);
    @(negedge clk);
    rst_n = 1'b0;
    bus.fft_out_valid = 1'b0;
    #1;
    checkZeroOutputs("abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tbBin = 0;
    cvTimes.delete();
    applyIdle(40);
    checkOutput("abortNoResult", cvTimes.size(), 0);
    sendFrame(0, 1'b0, -1); applyIdle(1); waitDrain();
    checkOutput("abortCount", cvTimes.size(), 1);

    cvTimes.delete();
    sendPartial(4, 500);
    sendFrame(0, 1'b1, -1); applyIdle(1); waitDrain();
    checkOutput("sofRestartCount", cvTimes.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
